// File: rtl/cdp_dp_sqsum_in_pkg.sv
// CDP sum-of-squares input stage: shared types and constants.
// Field offsets, FSM encoding and window helpers.
package cdp_dp_sqsum_in_pkg;

  localparam int DW   = 8;
  localparam int SQW  = 16;
  localparam int SUMW = 18;
  localparam int MAXN = 9;

  localparam int IN_PDW  = 31;
  localparam int OUT_PDW = 28;

  localparam int DATA_LSB  = 0;
  localparam int DATA_MSB  = 7;
  localparam int CHN_END   = 8;
  localparam int LAYER_END = 9;

  localparam int OUT_DATA_LSB  = 0;
  localparam int OUT_SUM_LSB   = 8;
  localparam int OUT_CHN_END   = 26;
  localparam int OUT_LAYER_END = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic           vld;
    logic [DW-1:0]  data;
    logic [SQW-1:0] sq;
    logic           chn_end;
    logic           layer_end;
  } sr_t;

  function automatic logic [2:0] len2h(
    input logic [1:0] len
  );
    return 3'(len) + 3'd1;
  endfunction

endpackage

// File: rtl/cdp_dp_sqsum_tree.sv
// Masked adder of window squares.
// Taps 0..2h contribute when their valid bit is set.
module cdp_dp_sqsum_tree
  import cdp_dp_sqsum_in_pkg::*;
(
  input  logic [MAXN-1:0][SQW-1:0] sq,
  input  logic [MAXN-1:0]          vld,
  input  logic [2:0]               h,
  output logic [SUMW-1:0]          sum
);

  // accumulate zero-extended squares inside the window
  always_comb begin
    sum = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (vld[i] && (i <= 2 * int'(h)))
        sum = sum + SUMW'(sq[i]);
    end
  end

endmodule

// File: rtl/cdp_dp_sqsum_in.sv
// CDP datapath input stage: cross-channel
// sum of squares over an N=3/5/7/9 window.
module cdp_dp_sqsum_in
  import cdp_dp_sqsum_in_pkg::*;
(
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               cdp_rdma2dp_valid,
  output logic               cdp_rdma2dp_ready,
  input  logic [IN_PDW-1:0]  cdp_rdma2dp_pd,
  input  logic [1:0]         reg2dp_normalz_len,
  output logic               sq2dp_valid,
  input  logic               sq2dp_ready,
  output logic [OUT_PDW-1:0] sq2dp_pd,
  output logic               sq2dp_layer_done
);

  sr_t    sr_q [MAXN];
  sr_t    sr_n [MAXN];
  sr_t    din;
  sr_t    ctr;
  state_t state;
  state_t state_n;

  logic [2:0] h_q;
  logic [2:0] h_eff;
  logic [2:0] cnt;
  logic [2:0] cnt_n;

  logic can_adv;
  logic in_fire;
  logic flush_step;
  logic adv;
  logic grp_start;

  logic [MAXN-1:0][SQW-1:0] sq_vec;
  logic [MAXN-1:0]          vld_vec;
  logic [SUMW-1:0]          sum;

  logic signed [DW-1:0]   d;
  logic signed [2*DW-1:0] prod;

  assign can_adv    = !sq2dp_valid || sq2dp_ready;
  assign cdp_rdma2dp_ready = nvdla_core_rstn
                          && (state != FLUSH)
                          && can_adv;
  assign in_fire    = cdp_rdma2dp_valid
                   && cdp_rdma2dp_ready;
  assign flush_step = (state == FLUSH);
  assign adv        = (in_fire || flush_step)
                   && can_adv;
  assign grp_start  = in_fire && (state == IDLE);

  // the first beat of a group sees the live length
  assign h_eff = (state == IDLE)
               ? len2h(reg2dp_normalz_len)
               : h_q;

  assign d    = cdp_rdma2dp_pd[DATA_MSB:DATA_LSB];
  assign prod = d * d;

  assign sq2dp_layer_done = sq2dp_valid
                         && sq2dp_ready
                         && sq2dp_pd[OUT_LAYER_END];

  // new head entry: input beat or flush bubble
  always_comb begin
    din = '0;
    if (in_fire) begin
      din.vld       = 1'b1;
      din.data      = d;
      din.sq        = prod;
      din.chn_end   = cdp_rdma2dp_pd[CHN_END];
      din.layer_end = cdp_rdma2dp_pd[LAYER_END];
    end
  end

  // post-shift view; a new group drops fully
  // emitted leftovers so a larger window cannot
  // re-emit or sum them
  always_comb begin
    sr_n[0] = din;
    for (int i = 1; i < MAXN; i++) begin
      sr_n[i] = sr_q[i-1];
      if (grp_start)
        sr_n[i].vld = 1'b0;
    end
  end

  // flatten window taps for the adder
  always_comb begin
    sq_vec  = '0;
    vld_vec = '0;
    for (int i = 0; i < MAXN; i++) begin
      sq_vec[i]  = sr_n[i].sq;
      vld_vec[i] = sr_n[i].vld;
    end
  end

  assign ctr = sr_n[{1'b0, h_eff}];

  cdp_dp_sqsum_tree u_tree (
    .sq  (sq_vec),
    .vld (vld_vec),
    .h   (h_eff),
    .sum (sum)
  );

  // group FSM: next state and flush counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (in_fire)
          state_n = cdp_rdma2dp_pd[CHN_END]
                  ? FLUSH : RUN;
      end
      RUN: begin
        if (in_fire && cdp_rdma2dp_pd[CHN_END])
          state_n = FLUSH;
      end
      FLUSH: begin
        if (adv) begin
          if (cnt == h_q - 3'd1) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM, latched window and shift register
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state <= IDLE;
      cnt   <= '0;
      h_q   <= 3'd1;
      for (int i = 0; i < MAXN; i++)
        sr_q[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (grp_start)
        h_q <= len2h(reg2dp_normalz_len);
      if (adv)
        sr_q <= sr_n;
    end
  end

  // output register: load centre on advance
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      sq2dp_valid <= 1'b0;
      sq2dp_pd    <= '0;
    end else if (adv) begin
      sq2dp_valid <= ctr.vld;
      if (ctr.vld)
        sq2dp_pd <= {ctr.layer_end,
                     ctr.chn_end,
                     sum,
                     ctr.data};
    end else if (sq2dp_ready) begin
      sq2dp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdp_dp_sqsum_in.sv
// Bench for cdp_dp_sqsum_in: group-level model
// of windowed sums, directed groups, stalls.
module tb_cdp_dp_sqsum_in;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_pd;
  logic [1:0]  nlen;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_pd;
  logic        ld;

  typedef struct {
    int data;
    int sum;
    bit ce;
    bit le;
  } exp_t;

  exp_t exp_q[$];
  int   act_sums[$];
  int   errors   = 0;
  int   checks   = 0;
  int   ld_count = 0;
  bit   rnd_ready = 0;
  bit   chg_len   = 0;

  cdp_dp_sqsum_in dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .cdp_rdma2dp_valid  (in_valid),
    .cdp_rdma2dp_ready  (in_ready),
    .cdp_rdma2dp_pd     (in_pd),
    .reg2dp_normalz_len (nlen),
    .sq2dp_valid        (out_valid),
    .sq2dp_ready        (out_ready),
    .sq2dp_pd           (out_pd),
    .sq2dp_layer_done   (ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // window sum from group contents, clipped at edges
  function automatic void model_group(
    input int d[$], input int h, input bit le);
    int   n;
    int   s;
    exp_t e;
    n = d.size();
    for (int j = 0; j < n; j++) begin
      s = 0;
      for (int k = j - h; k <= j + h; k++)
        if (k >= 0 && k < n)
          s += d[k] * d[k];
      e.data = d[j];
      e.sum  = s;
      e.ce   = (j == n - 1);
      e.le   = le && (j == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic send_beat(input int data,
                           input bit ce,
                           input bit le);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid       = 1'b1;
    in_pd[7:0]     = 8'(data);
    in_pd[8]       = ce;
    in_pd[9]       = le;
    in_pd[30:10]   = 21'($urandom);
    for (int t = 0; t < 300; t++) begin
      #1;
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept: ready never seen");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_group(input int d[$],
                            input int len,
                            input bit le);
    model_group(d, len + 1, le);
    nlen = 2'(len);
    for (int i = 0; i < d.size(); i++) begin
      send_beat(d[i], i == d.size() - 1,
                le && (i == d.size() - 1));
      if (i == 0 && chg_len)
        nlen = ~nlen;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk("drain", longint'(exp_q.size()), 0);
  endtask

  task automatic chk_log(input string name,
                         input int e[$]);
    chk({name, "_n"}, longint'(act_sums.size()),
        longint'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < act_sums.size())
        chk(name, longint'(act_sums[i]),
            longint'(e[i]));
    act_sums.delete();
  endtask

  // downstream ready: always or coin flip
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rnd_ready
                ? 1'($urandom_range(0, 1))
                : 1'b1;
    end
  end

  // per-cycle compare against the model queue
  initial begin
    exp_t        e;
    bit          pstall;
    logic [27:0] ppd;
    pstall = 0;
    ppd    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        pstall = 0;
        continue;
      end
      if (pstall) begin
        chk("stall_valid",
            longint'(out_valid), 1);
        chk("stall_pd", longint'(out_pd),
            longint'(ppd));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_out: data %0d",
                   out_pd[7:0]);
        end else begin
          e = exp_q.pop_front();
          chk("data", longint'(out_pd[7:0]),
              longint'(e.data & 255));
          chk("sum", longint'(out_pd[25:8]),
              longint'(e.sum));
          chk("chn_end", longint'(out_pd[26]),
              longint'(e.ce));
          chk("layer_end", longint'(out_pd[27]),
              longint'(e.le));
          chk("layer_done", longint'(ld),
              longint'(e.le));
          act_sums.push_back(int'(out_pd[25:8]));
        end
        if (ld)
          ld_count++;
      end else begin
        chk("layer_done_idle", longint'(ld), 0);
      end
      pstall = out_valid && !out_ready;
      ppd    = out_pd;
    end
  end

  initial begin
    int g[$];
    int g2[$];
    int e[$];
    int ld0;
    in_valid = 1'b0;
    in_pd    = '0;
    nlen     = 2'd0;
    rstn     = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_pd", longint'(out_pd), 0);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_ld", longint'(ld), 0);
    @(negedge clk);
    rstn = 1'b1;

    // N=3, [1,2,3]
    g = {1, 2, 3};
    send_group(g, 0, 0);
    chk("flush_rdy0", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("flush_rdy1", longint'(in_ready), 1);
    drain();
    e = {5, 14, 13};
    chk_log("t1", e);

    // N=5, all -128
    g = {-128, -128, -128, -128, -128};
    send_group(g, 1, 0);
    drain();
    e = {49152, 65536, 81920, 65536, 49152};
    chk_log("t2", e);

    // N=9, single element, layer end
    ld0 = ld_count;
    g = {10};
    send_group(g, 3, 1);
    for (int i = 0; i < 4; i++) begin
      chk("n9_flush", longint'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    chk("n9_idle", longint'(in_ready), 1);
    drain();
    e = {100};
    chk_log("t3", e);
    chk("ld_pulses", longint'(ld_count - ld0), 1);

    // N=3, back-to-back groups
    g  = {1, 2};
    g2 = {3, 4};
    send_group(g, 0, 0);
    send_group(g2, 0, 0);
    drain();
    e = {5, 5, 25, 25};
    chk_log("t4", e);

    // N=7, 64 channels, random stalls,
    // length changed after first beat
    g.delete();
    for (int i = 0; i < 64; i++)
      g.push_back(int'($urandom_range(0, 255)) - 128);
    rnd_ready = 1;
    chg_len   = 1;
    send_group(g, 2, 0);
    drain();
    rnd_ready = 0;
    chg_len   = 0;
    act_sums.delete();

    // reset after 3 of 8 beats (N=7)
    nlen = 2'd2;
    send_beat(7, 0, 0);
    send_beat(-5, 0, 0);
    send_beat(9, 0, 0);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_pd", longint'(out_pd), 0);
    chk("mid_rst_ready", longint'(in_ready), 0);
    chk("mid_rst_ld", longint'(ld), 0);
    @(negedge clk);
    rstn = 1'b1;
    g = {2};
    send_group(g, 0, 0);
    chk("post_rst_flush", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("post_rst_idle", longint'(in_ready), 1);
    drain();
    e = {4};
    chk_log("t6", e);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
